// File: rtl/spart_ctrl.sv
// spart_ctrl: processor bus front end of a SPART, with baud tick generator and RX/TX handshakes
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   iocs, iorw        : chip select and direction (1 = read) of a processor request
//   ioaddr, db_in     : register address (00 data, 01 status, 10/11 divisor low/high) and write data
//   db_out, io_ack    : registered read data and one-cycle completion pulse
//   rda, rx_data      : receiver data-available flag and received byte
//   rx_read           : one-cycle read strobe to the receiver
//   tbr               : transmit buffer ready
//   tx_load, tx_data  : one-cycle load strobe and byte for the transmitter
//   baud_en           : one-cycle sample tick for receiver and transmitter
module spart_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    input  logic [7:0] db_in,
    output logic [7:0] db_out,
    output logic       io_ack,
    input  logic       rda,
    input  logic [7:0] rx_data,
    output logic       rx_read,
    input  logic       tbr,
    output logic       tx_load,
    output logic [7:0] tx_data,
    output logic       baud_en
);
    // DECODE holds the accepted request for one cycle so every completion is timed from the accept edge
    typedef enum logic [2:0] {IDLE, DECODE, RX_STB, RX_CAP, TX_WAIT} state_t;

    state_t      state_q, state_d;
    logic        rw_q, rw_d, rda_q, rda_d;
    logic [1:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d, db_out_q, db_out_d, tx_data_q, tx_data_d;
    logic        io_ack_q, io_ack_d, rx_read_q, rx_read_d, tx_load_q, tx_load_d, baud_q, baud_d;
    logic [15:0] div_q, div_d, cnt_q, cnt_d;
    logic        div_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rw_q      <= 1'b0;
            rda_q     <= 1'b0;
            addr_q    <= 2'b00;
            wdata_q   <= 8'h00;
            db_out_q  <= 8'h00;
            tx_data_q <= 8'h00;
            io_ack_q  <= 1'b0;
            rx_read_q <= 1'b0;
            tx_load_q <= 1'b0;
            baud_q    <= 1'b0;
            div_q     <= 16'd39;
            cnt_q     <= 16'd39;
        end else begin
            state_q   <= state_d;
            rw_q      <= rw_d;
            rda_q     <= rda_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            db_out_q  <= db_out_d;
            tx_data_q <= tx_data_d;
            io_ack_q  <= io_ack_d;
            rx_read_q <= rx_read_d;
            tx_load_q <= tx_load_d;
            baud_q    <= baud_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        rda_d     = rda_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        db_out_d  = db_out_q;
        tx_data_d = tx_data_q;
        io_ack_d  = 1'b0;
        rx_read_d = 1'b0;
        tx_load_d = 1'b0;
        div_wr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (iocs) begin
                    state_d = DECODE;
                    rw_d    = iorw;
                    addr_d  = ioaddr;
                    wdata_d = db_in;
                    rda_d   = rda;
                end
            end
            DECODE: begin
                state_d  = IDLE;
                io_ack_d = 1'b1;
                if (addr_q == 2'b00 && rw_q && rda_q) begin
                    // rx_read is high while in RX_STB; the byte is captured one cycle later in RX_CAP
                    state_d   = RX_STB;
                    io_ack_d  = 1'b0;
                    rx_read_d = 1'b1;
                end else if (addr_q == 2'b00 && !rw_q && !tbr) begin
                    state_d  = TX_WAIT;
                    io_ack_d = 1'b0;
                end else if (addr_q == 2'b00 && !rw_q) begin
                    tx_load_d = 1'b1;
                    tx_data_d = wdata_q;
                end else if (rw_q) begin
                    // a data read without rda keeps the previous db_out
                    db_out_d = addr_q[1] ? (addr_q[0] ? div_q[15:8] : div_q[7:0])
                             : addr_q[0] ? {6'b0, tbr, rda} : db_out_q;
                end else begin
                    div_wr = addr_q[1];
                end
            end
            RX_STB: state_d = RX_CAP;
            RX_CAP: begin
                state_d  = IDLE;
                io_ack_d = 1'b1;
                db_out_d = rx_data;
            end
            TX_WAIT: begin
                if (tbr) begin
                    state_d   = IDLE;
                    io_ack_d  = 1'b1;
                    tx_load_d = 1'b1;
                    tx_data_d = wdata_q;
                end
            end
            default: state_d = IDLE;
        endcase
        div_d  = div_q;
        cnt_d  = cnt_q - 16'd1;
        baud_d = 1'b0;
        // a divisor write restarts the count from the new value and suppresses the tick on that edge
        if (div_wr) begin
            div_d = addr_q[0] ? {wdata_q, div_q[7:0]} : {div_q[15:8], wdata_q};
            cnt_d = div_d;
        end else if (cnt_q == 16'd0) begin
            baud_d = 1'b1;
            cnt_d  = div_q;
        end
    end

    assign db_out  = db_out_q;
    assign io_ack  = io_ack_q;
    assign rx_read = rx_read_q;
    assign tx_load = tx_load_q;
    assign tx_data = tx_data_q;
    assign baud_en = baud_q;
endmodule

// File: tb/tb_spart_ctrl.sv
// tb_spart_ctrl: self-checking bench for spart_ctrl with a transaction scoreboard
module tb_spart_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1, iocs = 1'b0, iorw = 1'b0, rda = 1'b0, tbr = 1'b1;
    logic [1:0] ioaddr = 2'b00;
    logic [7:0] db_in = 8'h00, rx_data = 8'h00, rx_byte = 8'h00;
    logic [7:0] db_out, tx_data;
    logic io_ack, rx_read, tx_load, baud_en;
    logic rx_prev;
    int errors = 0, checks = 0;
    int rx_cnt = 0, tx_cnt = 0, ack_cnt = 0, both_cnt = 0;

    typedef struct { int lat; logic [7:0] db; } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    spart_ctrl dut (
        .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .db_in(db_in),
        .db_out(db_out), .io_ack(io_ack), .rda(rda), .rx_data(rx_data), .rx_read(rx_read),
        .tbr(tbr), .tx_load(tx_load), .tx_data(tx_data), .baud_en(baud_en)
    );

    always @(negedge clk) begin
        if (rx_read) rx_cnt++;
        if (tx_load) tx_cnt++;
        if (io_ack) ack_cnt++;
        if (rx_read && tx_load) both_cnt++;
    end

    // receiver model: rx_byte is valid only in the cycle after rx_read, garbage otherwise
    always begin
        @(negedge clk);
        rx_prev = rx_read;
        @(posedge clk);
        #1 rx_data = rx_prev ? rx_byte : ~rx_byte;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rw, input logic [1:0] a, input logic [7:0] d,
                         input int lat, input logic [7:0] db);
        exp_t e;
        e.lat = lat;
        e.db  = db;
        sb.push_back(e);
        iocs = 1'b1; iorw = rw; ioaddr = a; db_in = d;
        tick();
        iocs = 1'b0;
    endtask

    task automatic wait_ack(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!io_ack && lat < 50);
        if (!io_ack) lat = -1;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({io_ack, rx_read, tx_load, baud_en} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got %b need 0000", {io_ack, rx_read, tx_load, baud_en});
        end
        checks++;
        if (db_out !== 8'h00 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: db_out=%h tx_data=%h need 00 00", db_out, tx_data);
        end
        rst = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!baud_en && n < 100);
        checks++;
        if (n != 40) begin errors++; $display("FAIL baud_first: got %0d need 40", n); end
        n = 0;
        do begin tick(); n++; end while (!baud_en && n < 100);
        checks++;
        if (n != 40) begin errors++; $display("FAIL baud_period: got %0d need 40", n); end
    endtask

    task automatic test_divisor();
        int lat, n;
        exp_t e;
        issue(1'b0, 2'b10, 8'h09, 1, 8'h00);
        wait_ack(lat); e = sb.pop_front();
        checks++;
        if (lat != e.lat || db_out !== e.db) begin
            errors++; $display("FAIL div_wr_lo: lat=%0d db_out=%h need %0d %h", lat, db_out, e.lat, e.db);
        end
        issue(1'b0, 2'b11, 8'h00, 1, 8'h00);
        wait_ack(lat); e = sb.pop_front();
        checks++;
        if (lat != e.lat || db_out !== e.db) begin
            errors++; $display("FAIL div_wr_hi: lat=%0d db_out=%h need %0d %h", lat, db_out, e.lat, e.db);
        end
        checks++;
        if (baud_en !== 1'b0) begin errors++; $display("FAIL div_wr_tick: baud_en=%b need 0", baud_en); end
        n = 0;
        do begin tick(); n++; end while (!baud_en && n < 100);
        checks++;
        if (n != 10) begin errors++; $display("FAIL div9_first: got %0d need 10", n); end
        n = 0;
        do begin tick(); n++; end while (!baud_en && n < 100);
        checks++;
        if (n != 10) begin errors++; $display("FAIL div9_period: got %0d need 10", n); end
        issue(1'b1, 2'b10, 8'h00, 1, 8'h09);
        wait_ack(lat); e = sb.pop_front();
        checks++;
        if (lat != e.lat || db_out !== e.db) begin
            errors++; $display("FAIL div_rd_lo: lat=%0d db_out=%h need %0d %h", lat, db_out, e.lat, e.db);
        end
        issue(1'b1, 2'b11, 8'h00, 1, 8'h00);
        wait_ack(lat); e = sb.pop_front();
        checks++;
        if (lat != e.lat || db_out !== e.db) begin
            errors++; $display("FAIL div_rd_hi: lat=%0d db_out=%h need %0d %h", lat, db_out, e.lat, e.db);
        end
        issue(1'b0, 2'b10, 8'h00, 1, 8'h00);
        wait_ack(lat); e = sb.pop_front();
        checks++;
        if (lat != e.lat || baud_en !== 1'b0) begin
            errors++; $display("FAIL div0_wr: lat=%0d baud_en=%b need %0d 0", lat, baud_en, e.lat);
        end
        n = 0;
        repeat (20) begin tick(); if (baud_en) n++; end
        checks++;
        if (n != 20) begin errors++; $display("FAIL div0_const: high %0d of 20 cycles need 20", n); end
    endtask

    task automatic test_receive();
        int lat, r0;
        exp_t e;
        rda = 1'b1; rx_byte = 8'hA5; r0 = rx_cnt;
        issue(1'b1, 2'b00, 8'h00, 3, 8'hA5);
        checks++;
        if (rx_read !== 1'b0) begin errors++; $display("FAIL rx_read_early: got %b need 0", rx_read); end
        tick();
        checks++;
        if (rx_read !== 1'b1 || io_ack !== 1'b0) begin
            errors++; $display("FAIL rx_read_n1: rx_read=%b io_ack=%b need 1 0", rx_read, io_ack);
        end
        wait_ack(lat); lat++; e = sb.pop_front();
        checks++;
        if (lat != e.lat || db_out !== e.db) begin
            errors++; $display("FAIL rx_read_data: lat=%0d db_out=%h need %0d %h", lat, db_out, e.lat, e.db);
        end
        checks++;
        if (rx_cnt - r0 != 1) begin errors++; $display("FAIL rx_read_count: got %0d need 1", rx_cnt - r0); end
        rda = 1'b0; r0 = rx_cnt;
        issue(1'b1, 2'b00, 8'h00, 1, 8'hA5);
        wait_ack(lat); e = sb.pop_front();
        checks++;
        if (lat != e.lat || db_out !== e.db) begin
            errors++; $display("FAIL rx_empty: lat=%0d db_out=%h need %0d %h", lat, db_out, e.lat, e.db);
        end
        tick();
        checks++;
        if (rx_cnt != r0) begin errors++; $display("FAIL rx_empty_strobe: got %0d need 0", rx_cnt - r0); end
    endtask

    task automatic test_tx_wait();
        int lat, t0, a0;
        exp_t e;
        tbr = 1'b0; t0 = tx_cnt; a0 = ack_cnt;
        issue(1'b0, 2'b00, 8'h3C, 6, 8'hA5);
        for (int i = 1; i <= 5; i++) begin
            iocs = (i == 2 || i == 3); iorw = 1'b1; ioaddr = 2'b01;
            tick();
        end
        iocs = 1'b0; tbr = 1'b1;
        wait_ack(lat); lat += 5; e = sb.pop_front();
        checks++;
        if (lat != e.lat || db_out !== e.db) begin
            errors++; $display("FAIL tx_wait_ack: lat=%0d db_out=%h need %0d %h", lat, db_out, e.lat, e.db);
        end
        checks++;
        if (tx_load !== 1'b1 || tx_data !== 8'h3C) begin
            errors++; $display("FAIL tx_wait_load: tx_load=%b tx_data=%h need 1 3c", tx_load, tx_data);
        end
        tick();
        checks++;
        if (tx_load !== 1'b0 || io_ack !== 1'b0) begin
            errors++; $display("FAIL tx_wait_pulse: tx_load=%b io_ack=%b need 0 0", tx_load, io_ack);
        end
        repeat (4) tick();
        checks++;
        if (tx_cnt - t0 != 1 || ack_cnt - a0 != 1) begin
            errors++; $display("FAIL tx_wait_once: loads=%0d acks=%0d need 1 1", tx_cnt - t0, ack_cnt - a0);
        end
    endtask

    task automatic test_status();
        int lat, r0, t0;
        exp_t e;
        tbr = 1'b1; rda = 1'b0;
        issue(1'b1, 2'b01, 8'h00, 1, 8'h02);
        wait_ack(lat); e = sb.pop_front();
        checks++;
        if (lat != e.lat || db_out !== e.db) begin
            errors++; $display("FAIL status_tbr: lat=%0d db_out=%h need %0d %h", lat, db_out, e.lat, e.db);
        end
        tbr = 1'b0; rda = 1'b1; r0 = rx_cnt;
        issue(1'b1, 2'b01, 8'h00, 1, 8'h01);
        wait_ack(lat); e = sb.pop_front();
        checks++;
        if (lat != e.lat || db_out !== e.db || rx_cnt != r0) begin
            errors++; $display("FAIL status_rda: lat=%0d db_out=%h rx=%0d need %0d %h 0", lat, db_out, rx_cnt - r0, e.lat, e.db);
        end
        tbr = 1'b1; rda = 1'b0; t0 = tx_cnt;
        issue(1'b0, 2'b01, 8'hFF, 1, 8'h01);
        wait_ack(lat); e = sb.pop_front();
        tick();
        checks++;
        if (lat != e.lat || db_out !== e.db || tx_cnt != t0) begin
            errors++; $display("FAIL status_wr: lat=%0d db_out=%h tx=%0d need %0d %h 0", lat, db_out, tx_cnt - t0, e.lat, e.db);
        end
    endtask

    task automatic test_reset_mid();
        int lat, t0, a0;
        exp_t e;
        tbr = 1'b0; t0 = tx_cnt;
        iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00; db_in = 8'h77;
        tick();
        iocs = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        a0 = ack_cnt;
        checks++;
        if ({io_ack, tx_load} !== 2'b00 || db_out !== 8'h00 || tx_data !== 8'h00) begin
            errors++; $display("FAIL rst_mid: io_ack=%b tx_load=%b db_out=%h tx_data=%h need 0 0 00 00", io_ack, tx_load, db_out, tx_data);
        end
        rst = 1'b0; tbr = 1'b1;
        issue(1'b1, 2'b10, 8'h00, 1, 8'h27);
        wait_ack(lat); e = sb.pop_front();
        checks++;
        if (lat != e.lat || db_out !== e.db) begin
            errors++; $display("FAIL rst_div_lo: lat=%0d db_out=%h need %0d %h", lat, db_out, e.lat, e.db);
        end
        issue(1'b1, 2'b11, 8'h00, 1, 8'h00);
        wait_ack(lat); e = sb.pop_front();
        tick();
        checks++;
        if (lat != e.lat || db_out !== e.db) begin
            errors++; $display("FAIL rst_div_hi: lat=%0d db_out=%h need %0d %h", lat, db_out, e.lat, e.db);
        end
        checks++;
        if (tx_cnt != t0 || ack_cnt - a0 != 2) begin
            errors++; $display("FAIL rst_drop: loads=%0d acks=%0d need 0 2", tx_cnt - t0, ack_cnt - a0);
        end
    endtask

    task automatic test_back_to_back();
        int a0, first, second, bad;
        tbr = 1'b1; rda = 1'b0; a0 = ack_cnt; first = -1; second = -1; bad = 0;
        iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b01;
        for (int i = 1; i <= 90; i++) begin
            tick();
            if (io_ack && db_out !== 8'h02) bad++;
            if (baud_en) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        iocs = 1'b0;
        tick();
        checks++;
        if (ack_cnt - a0 != 45 || bad != 0) begin
            errors++; $display("FAIL b2b_acks: acks=%0d bad_data=%0d need 45 0", ack_cnt - a0, bad);
        end
        checks++;
        if (second - first != 40) begin
            errors++; $display("FAIL b2b_baud: spacing=%0d need 40", second - first);
        end
    endtask

    initial begin
        test_reset();
        test_divisor();
        test_receive();
        test_tx_wait();
        test_status();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (both_cnt != 0) begin errors++; $display("FAIL rx_tx_overlap: got %0d need 0", both_cnt); end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d need 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
